// File: rtl/lbp_host_mem.sv
// lbp_host_mem
// Frame buffer between a raster pixel source and the LBP engine.
//   load stream : in_valid/in_data/in_ready fill gmem (and clear rmem) in raster order
//   gray port   : gray_req/gray_addr -> gray_data (1-cycle registered read), gray_ready
//   lbp port    : lbp_valid/lbp_addr/lbp_data write rmem, counted in lbp_wr_cnt
//   drain stream: after finish, out_valid/out_ready/out_addr/out_data stream rmem[0..N-1]
//   status      : err (sticky protocol error), done (drain complete)
module lbp_host_mem #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [7:0]    gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [7:0]    lbp_data,
    input  logic          finish,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [7:0]    out_data,
    output logic [AW:0]   lbp_wr_cnt,
    output logic          err,
    output logic          done
);
    localparam int            N     = IMG_W * IMG_H;
    localparam int            DEPTH = 2 ** AW;
    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [AW:0]   N_EXT = (AW + 1)'(N);

    typedef enum logic [1:0] {LOAD, SERVE, DRAIN, DONE} state_t;
    state_t state, state_nx;

    // Full 2^AW depth so an out-of-range gray read wraps modulo 2^AW;
    // only the first N entries are ever loaded or drained.
    logic [7:0] gmem [DEPTH];
    logic [7:0] rmem [DEPTH];

    // Shared pointer: load write address in LOAD, drain read address in DRAIN.
    logic [AW-1:0] cnt;

    logic in_hs, gray_oob, lbp_oob, lbp_ok, out_acc, out_last, drain_ld, err_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        gray_ready = 1'b0;
        done       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST) state_nx = SERVE;
            end
            SERVE: begin
                gray_ready = 1'b1;
                if (finish) state_nx = DRAIN;
            end
            DRAIN: begin
                if (out_acc && out_last) state_nx = DONE;
            end
            DONE: done = 1'b1;
            default: state_nx = LOAD;
        endcase
    end

    assign in_hs    = in_valid && in_ready;
    assign gray_oob = {1'b0, gray_addr} >= N_EXT;
    assign lbp_oob  = {1'b0, lbp_addr} >= N_EXT;
    assign lbp_ok   = (state == SERVE) && lbp_valid && !lbp_oob;
    assign out_acc  = out_valid && out_ready;
    assign out_last = out_addr == LAST;
    // Fetch the next entry when the output register is empty or being
    // consumed this cycle, except after the final entry.
    assign drain_ld = (state == DRAIN) && (!out_valid || (out_ready && !out_last));
    assign err_set  = ((gray_req || lbp_valid) && state != SERVE)
                    || (state == SERVE && gray_req && gray_oob)
                    || (lbp_valid && lbp_oob);

    // Memories carry no reset; a new LOAD rewrites both.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            gmem[cnt] <= in_data;
            rmem[cnt] <= 8'h00;
        end else if (lbp_ok) begin
            rmem[lbp_addr] <= lbp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            gray_data  <= '0;
            lbp_wr_cnt <= '0;
            err        <= 1'b0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
        end else begin
            if (in_hs)         cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
            else if (drain_ld) cnt <= cnt + AW'(1);

            if (state == SERVE && gray_req) gray_data <= gmem[gray_addr];

            if (lbp_ok && lbp_wr_cnt != '1) lbp_wr_cnt <= lbp_wr_cnt + (AW + 1)'(1);

            if (err_set) err <= 1'b1;

            if (drain_ld) begin
                out_valid <= 1'b1;
                out_addr  <= cnt;
                out_data  <= rmem[cnt];
            end else if (out_acc && out_last) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lbp_host_mem.sv
module tb_lbp_host_mem;
    localparam int AW = 5;
    localparam int N  = 16;

    logic          clk = 0, reset = 1;
    logic          in_valid = 0;
    logic [7:0]    in_data = 0;
    logic          in_ready, gray_ready;
    logic          gray_req = 0;
    logic [AW-1:0] gray_addr = 0;
    logic [7:0]    gray_data;
    logic          lbp_valid = 0;
    logic [AW-1:0] lbp_addr = 0;
    logic [7:0]    lbp_data = 0;
    logic          finish = 0;
    logic          out_valid;
    logic          out_ready = 0;
    logic [AW-1:0] out_addr;
    logic [7:0]    out_data;
    logic [AW:0]   lbp_wr_cnt;
    logic          err, done;

    lbp_host_mem #(.IMG_W(4), .IMG_H(4), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .lbp_wr_cnt(lbp_wr_cnt), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] gm [N];
    logic [7:0] rm [N];
    logic [AW:0] exp_cnt;
    logic [7:0] rdq [$];
    logic [AW+7:0] drq [$];

    task automatic apply_reset();
        @(negedge clk);
        reset = 1; in_valid = 0; gray_req = 0; lbp_valid = 0; finish = 0; out_ready = 0;
        exp_cnt = '0;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic load_image(input logic [7:0] base, input bit gaps);
        int i = 0, c = 0;
        while (i < N) begin
            @(negedge clk);
            if (gaps && c % 3 == 2) in_valid = 0;
            else begin
                if (i == N - 1) begin
                    checks++;
                    if (gray_ready !== 1'b0) begin errors++; $display("FAIL gray_ready_early got %b exp 0", gray_ready); end
                end
                in_valid = 1; in_data = base + 8'(i);
                gm[i] = base + 8'(i); rm[i] = 8'h00; i++;
            end
            c++;
        end
        @(negedge clk);
        in_valid = 0;
        checks++;
        if (gray_ready !== 1'b1) begin errors++; $display("FAIL gray_ready_after_load got %b exp 1", gray_ready); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_after_load got %b exp 0", in_ready); end
    endtask

    // Requests every cycle; each expected value is pushed when the request is
    // driven and popped one cycle later. Finally checks that gray_data holds.
    task automatic do_reads(input int start, input int n);
        logic [7:0] e, last;
        last = 8'h00;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rdq.size() > 0) begin
                e = rdq.pop_front(); checks++;
                if (gray_data !== e) begin errors++; $display("FAIL gray_read got %h exp %h", gray_data, e); end
            end
            gray_req = 1; gray_addr = AW'(start + k);
            rdq.push_back(gm[(start + k) % N]);
        end
        @(negedge clk);
        e = rdq.pop_front(); last = e; checks++;
        if (gray_data !== e) begin errors++; $display("FAIL gray_read_last got %h exp %h", gray_data, e); end
        gray_req = 0; gray_addr = AW'(3);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gray_data !== last) begin errors++; $display("FAIL gray_hold got %h exp %h", gray_data, last); end
    endtask

    task automatic lbp_write(input logic [AW-1:0] a, input logic [7:0] d, input bit fin);
        @(negedge clk);
        lbp_valid = 1; lbp_addr = a; lbp_data = d; finish = fin;
        if (int'(a) < N) begin
            rm[a[3:0]] = d;
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
        @(negedge clk);
        lbp_valid = 0; finish = 0;
    endtask

    // Drains the result stream, stalling stall_n cycles when stall_addr is presented.
    task automatic do_drain(input int stall_addr, input int stall_n);
        int cyc = 0, stalls = 0;
        logic [AW+7:0] e;
        for (int i = 0; i < N; i++) drq.push_back({AW'(i), rm[i]});
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_early got %b exp 0", out_valid); end
        while (drq.size() > 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!out_valid) begin
                checks++; errors++;
                $display("FAIL drain_bubble got out_valid 0 exp 1 at cycle %0d", cyc);
                out_ready = 1;
            end else if (int'(out_addr) == stall_addr && stalls < stall_n) begin
                out_ready = 0; stalls++;
                e = drq[0]; checks++;
                if ({out_addr, out_data} !== e) begin
                    errors++; $display("FAIL stall_hold got %h:%h exp %h:%h", out_addr, out_data, e[AW+7:8], e[7:0]);
                end
            end else begin
                out_ready = 1;
                e = drq.pop_front(); checks++;
                if ({out_addr, out_data} !== e) begin
                    errors++; $display("FAIL drain_data got %h:%h exp %h:%h", out_addr, out_data, e[AW+7:8], e[7:0]);
                end
            end
        end
        if (drq.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d left exp 0", drq.size());
            drq.delete();
        end
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done got %b exp 1", done); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_done got %b exp 0", out_valid); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, gray_ready, out_valid, err, done} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got %b exp 10000", {in_ready, gray_ready, out_valid, err, done});
        end
        checks++;
        if ({gray_data, out_addr, out_data, lbp_wr_cnt} !== '0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {gray_data, out_addr, out_data, lbp_wr_cnt});
        end
        reset = 0; exp_cnt = '0;
    endtask

    task automatic test_load_read();
        load_image(8'h10, 1'b1);
        do_reads(5, 1);
    endtask

    task automatic test_back_to_back();
        do_reads(0, N);
    endtask

    task automatic test_result_drain();
        lbp_write(AW'(5), 8'hA5, 1'b0);
        lbp_write(AW'(6), 8'h3C, 1'b1);
        checks++;
        if (lbp_wr_cnt !== exp_cnt) begin errors++; $display("FAIL lbp_wr_cnt got %0d exp %0d", lbp_wr_cnt, exp_cnt); end
        do_drain(5, 3);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_spurious got %b exp 0", err); end
    endtask

    task automatic test_errors();
        apply_reset();
        @(negedge clk);
        gray_req = 1; gray_addr = AW'(2);
        @(negedge clk);
        gray_req = 0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_req_in_load got %b exp 1", err); end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
        apply_reset();
        load_image(8'h10, 1'b0);
        lbp_write(AW'(3), 8'h77, 1'b0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clean got %b exp 0", err); end
        lbp_write(AW'(20), 8'hEE, 1'b0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_lbp_oob got %b exp 1", err); end
        checks++;
        if (lbp_wr_cnt !== exp_cnt) begin errors++; $display("FAIL lbp_wr_cnt_oob got %0d exp %0d", lbp_wr_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_serve();
        apply_reset();
        load_image(8'h40, 1'b0);
        lbp_write(AW'(9), 8'h99, 1'b0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0; exp_cnt = '0;
        @(negedge clk);
        checks++;
        if ({in_ready, gray_ready, err} !== 3'b100) begin
            errors++; $display("FAIL mid_serve_reset_flags got %b exp 100", {in_ready, gray_ready, err});
        end
        checks++;
        if (lbp_wr_cnt !== '0) begin errors++; $display("FAIL mid_serve_reset_cnt got %0d exp 0", lbp_wr_cnt); end
        load_image(8'h80, 1'b0);
        do_reads(0, N);
        lbp_write(AW'(0), 8'h00, 1'b1);
        do_drain(-1, 0);
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_back_to_back();
        test_result_drain();
        test_errors();
        test_reset_mid_serve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end
endmodule
